// File: rtl/generic_fifo_reader.sv
// Reader for the generic FIFO: packs PACK narrow words into one wide beat on a valid/ready master port.
// Define GENERIC_FIFO_READER_FLUSH_EN to add the flush input and the m_count word-count output.
module generic_fifo_reader #(
  parameter int MSB  = 3,
  parameter int LSB  = 0,
  parameter int PACK = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MSB:LSB]                  fifo_out,
  input  logic                            fifo_empty,
  output logic                            fifo_read,
  output logic [PACK*(MSB-LSB+1)-1:0]     m_data,
  output logic                            m_valid,
  input  logic                            m_ready
`ifdef GENERIC_FIFO_READER_FLUSH_EN
  ,
  input  logic                            flush,
  output logic [$clog2(PACK+1)-1:0]       m_count
`endif
);

  localparam int W  = MSB - LSB + 1;
  localparam int DW = PACK * W;
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW:0] PACK_C = (CW + 1)'(PACK);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t        state;
  logic [DW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          flushing;

  logic          flush_req;
  logic [CW:0]   inflight;
  logic          last_due;
  logic          out_free;
  logic          done;
  logic [DW-1:0] acc_n;
  logic [CW-1:0] cnt_n;

`ifdef GENERIC_FIFO_READER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Accumulator and count as they will be once the word due this cycle is captured.
  always_comb begin
    acc_n = acc;
    cnt_n = cnt;
    for (int k = 0; k < PACK; k++) begin
      if (pend && (cnt == CW'(k))) begin
        acc_n[k*W +: W] = fifo_out;
      end
    end
    if (pend) begin
      cnt_n = cnt + 1'b1;
    end
  end

  assign inflight = {1'b0, cnt} + {{CW{1'b0}}, pend};
  assign last_due = pend && ({1'b0, cnt} == (PACK_C - 1'b1));
  assign out_free = !m_valid || m_ready;

  // The last word landing with an idle output register guarantees the accumulator
  // clears on this edge, so the first read of the next beat can go out now.
  assign fifo_read = !reset && !fifo_empty && (state == FILL) && !flushing &&
                     ((inflight < PACK_C) || (last_due && !m_valid));

  assign done = (state == FILL) &&
                ((cnt_n == CW'(PACK)) || (flushing && (cnt_n != '0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      acc      <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      flushing <= 1'b0;
      m_data   <= '0;
      m_valid  <= 1'b0;
`ifdef GENERIC_FIFO_READER_FLUSH_EN
      m_count  <= '0;
`endif
    end else begin
      pend <= fifo_read;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (state)
        FILL: begin
          if (done) begin
            flushing <= 1'b0;
            if (out_free) begin
              m_data  <= acc_n;
              m_valid <= 1'b1;
`ifdef GENERIC_FIFO_READER_FLUSH_EN
              m_count <= cnt_n;
`endif
              acc     <= '0;
              cnt     <= '0;
            end else begin
              acc   <= acc_n;
              cnt   <= cnt_n;
              state <= HOLD;
            end
          end else begin
            acc      <= acc_n;
            cnt      <= cnt_n;
            flushing <= flushing || (flush_req && ((cnt != '0) || pend));
          end
        end
        HOLD: begin
          // The waiting beat moves out in the same edge the previous one is taken.
          if (m_valid && m_ready) begin
            m_data  <= acc;
            m_valid <= 1'b1;
`ifdef GENERIC_FIFO_READER_FLUSH_EN
            m_count <= cnt;
`endif
            acc     <= '0;
            cnt     <= '0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_fifo_reader.sv
// Directed bench for generic_fifo_reader with a behavioural FIFO and a beat scoreboard.
// Define GENERIC_FIFO_READER_FLUSH_EN to also exercise flush and m_count.
module tb_generic_fifo_reader;

  localparam int W    = 4;
  localparam int PACK = 4;
  localparam int DW   = W * PACK;

  logic          clk;
  logic          reset;
  logic [W-1:0]  fifo_out;
  logic          fifo_empty;
  logic          fifo_read;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          flush;
`ifdef GENERIC_FIFO_READER_FLUSH_EN
  logic [2:0]    m_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pop_empty = 0;
  int fifo_level = 0;

  logic [W-1:0]  fq[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cnt[$];
  int            acc_cyc[$];
  logic [DW-1:0] asm_beat;
  int            asm_n;

  logic          prev_hold;
  logic [DW-1:0] prev_data;

  generic_fifo_reader #(.MSB(W-1), .LSB(0), .PACK(PACK)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef GENERIC_FIFO_READER_FLUSH_EN
    ,
    .flush      (flush),
    .m_count    (m_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (fifo_level == 0);

  // Behavioural FIFO: registered read data, popping on an empty FIFO is recorded.
  always @(posedge clk) begin
    if (fifo_read) begin
      if (fq.size() == 0) begin
        pop_empty++;
      end else begin
        fifo_out   <= fq.pop_front();
        fifo_level <= fq.size();
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    reset   = rst;
    m_ready = rdy;
    flush   = fl;
  endtask

  task automatic pushWord(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_level = fq.size();
    asm_beat[asm_n*W +: W] = w;
    asm_n++;
    if (asm_n == PACK) begin
      exp_q.push_back(asm_beat);
      exp_cnt.push_back(PACK);
      asm_beat = '0;
      asm_n = 0;
    end
  endtask

  task automatic clearModel();
    fq.delete();
    fifo_level = 0;
    exp_q.delete();
    exp_cnt.delete();
    acc_cyc.delete();
    asm_beat = '0;
    asm_n = 0;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_pending_beats"}, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare on each accepted beat, plus hold stability.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", m_valid, 1);
        checkOutput("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("beat_unexpected", 1, 0);
        end else begin
          checkOutput("beat_data", m_data, exp_q.pop_front());
`ifdef GENERIC_FIFO_READER_FLUSH_EN
          checkOutput("beat_count", m_count, exp_cnt.pop_front());
`else
          void'(exp_cnt.pop_front());
`endif
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    asm_beat = '0;
    asm_n = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    #2 reset = 1'b1;

    // Single beat from a preloaded FIFO, cycle-exact read and valid timing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    clearModel();
    for (int k = 1; k <= 4; k++) pushWord(W'(k));
    @(negedge clk);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_fifo_read", fifo_read, 0);
`ifdef GENERIC_FIFO_READER_FLUSH_EN
    checkOutput("reset_m_count", m_count, 0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_fifo_read_c%0d", i), fifo_read, (i < 4) ? 1 : 0);
      checkOutput($sformatf("t1_m_valid_c%0d", i), m_valid, (i == 5) ? 1 : 0);
    end
    checkOutput("t1_beat_total", acc_cyc.size(), 1);
    waitDrain("t1", 10);

    // Streaming: back-to-back beats must come exactly PACK cycles apart.
    applyStimulus(1'b0, 1'b1, 1'b0);
    acc_cyc.delete();
    for (int k = 0; k < 12; k++) pushWord(W'(k));
    waitDrain("t2", 40);
    checkOutput("t2_beat_total", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      checkOutput("t2_gap01", acc_cyc[1] - acc_cyc[0], PACK);
      checkOutput("t2_gap12", acc_cyc[2] - acc_cyc[1], PACK);
    end

    // Backpressure: one beat presented, one held in the accumulator, reads stalled.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) pushWord(W'(k + 5));
    repeat (20) @(negedge clk);
    checkOutput("t3_m_valid", m_valid, 1);
    checkOutput("t3_m_data", m_data, 16'h8765);
    checkOutput("t3_fifo_read", fifo_read, 0);
    checkOutput("t3_fifo_level", fifo_level, 4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDrain("t3", 40);

    // FIFO runs dry mid-beat, then refills.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushWord(4'h3);
    pushWord(4'h9);
    repeat (10) @(negedge clk);
    checkOutput("t4_m_valid", m_valid, 0);
    checkOutput("t4_fifo_read", fifo_read, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushWord(4'h1);
    pushWord(4'h7);
    checkOutput("t4_expected_beat", exp_q[0], 16'h7193);
    waitDrain("t4", 20);

    // Asynchronous reset with a beat presented and a partial beat in flight.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) pushWord(W'(k));
    repeat (12) @(negedge clk);
    checkOutput("t5_pre_m_valid", m_valid, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("t5_async_m_valid", m_valid, 0);
    checkOutput("t5_async_m_data", m_data, 0);
    checkOutput("t5_async_fifo_read", fifo_read, 0);
    clearModel();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 10; k <= 13; k++) pushWord(W'(k));
    waitDrain("t5", 20);

`ifdef GENERIC_FIFO_READER_FLUSH_EN
    // Flush emits a zero-padded partial beat; flush while idle does nothing.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushWord(4'h5);
    pushWord(4'h6);
    repeat (4) @(negedge clk);
    exp_q.push_back(asm_beat);
    exp_cnt.push_back(asm_n);
    checkOutput("t6_expected_beat", asm_beat, 16'h0065);
    asm_beat = '0;
    asm_n = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDrain("t6", 10);
    acc_cyc.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t6_idle_m_valid", m_valid, 0);
    checkOutput("t6_idle_beats", acc_cyc.size(), 0);
`endif

    checkOutput("fifo_drained", fifo_level, 0);
    checkOutput("pop_on_empty", pop_empty, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
